// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared types and constants for the iterative M-extension unit
// Contents: funct3 opcode enum, FSM state enum, iteration counter width,
// and the preloaded results used by the divide-by-zero and signed-overflow fast paths.
package muldiv_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;
  localparam int MULDIV_CNT_W      = $clog2(MULDIV_DATA_WIDTH);

  // Fast-path results (RISC-V defined values, no trap).
  localparam logic [31:0] MULDIV_DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] MULDIV_OVF_QUO  = 32'h8000_0000;
  localparam logic [31:0] MULDIV_OVF_REM  = 32'h0000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response bundle between execute stage and the mul/div unit
// master: execute stage (drives start_i, op_i, src_a_i, src_b_i, flush_i)
// slave : muldiv_sequencer (drives busy_o, done_o, result_o)
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
);

  logic                     start_i;
  logic [OPCODE_LENGTH-1:0] op_i;
  logic [DATA_WIDTH-1:0]    src_a_i;
  logic [DATA_WIDTH-1:0]    src_b_i;
  logic                     flush_i;
  logic                     busy_o;
  logic                     done_o;
  logic [DATA_WIDTH-1:0]    result_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
// Ports: clk, reset (sync, active-high); bus (slave): start_i, op_i (funct3),
// src_a_i/src_b_i (rs1/rs2, latched at accept), flush_i (abort), busy_o (state != IDLE),
// done_o (one cycle, state DONE), result_o (registered, held until next accept).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = MULDIV_DATA_WIDTH,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] DIV0_QUO = W'(MULDIV_DIV0_QUO);
  localparam logic [W-1:0] MIN_NEG  = W'(MULDIV_OVF_QUO);
  localparam logic [W-1:0] OVF_REM  = W'(MULDIV_OVF_REM);

  muldiv_state_e            state_q, state_d;
  muldiv_op_e               op_q, op_d, op_in;
  logic [OPCODE_LENGTH-1:0] op_raw;
  logic [W-1:0]             a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     neg_q, neg_q_d, neg_r, neg_r_d;

  logic                     a_signed, b_signed, neg_a, neg_b, div0, ovf;
  logic [W-1:0]             mag_a, mag_b;
  logic [W:0]               mul_sum, rem_sh, trial;
  logic [2*W-1:0]           prod_fix;
  logic [W-1:0]             quo_fix, rem_fix, fix_val;

  // Operand intake: MUL keeps raw operands since its low word is sign-agnostic.
  assign op_raw   = bus.op_i;
  assign op_in    = muldiv_op_e'(op_raw[2:0]);
  assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign neg_a    = a_signed & bus.src_a_i[W-1];
  assign neg_b    = b_signed & bus.src_b_i[W-1];
  assign mag_a    = neg_a ? -bus.src_a_i : bus.src_a_i;
  assign mag_b    = neg_b ? -bus.src_b_i : bus.src_b_i;
  assign div0     = op_raw[2] && (bus.src_b_i == '0);
  assign ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (bus.src_a_i == MIN_NEG) && (bus.src_b_i == '1);

  // One iteration: carry-keeping add for multiply, 33-bit trial subtract for divide.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign rem_sh   = {acc_q[2*W-1:W], a_q[W-1]};
  assign trial    = rem_sh - {1'b0, b_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = neg_r ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    fix_val = acc_q[W-1:0];
    unique case (op_q)
      OP_MUL:                       fix_val = acc_q[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              fix_val = quo_fix;
      OP_REM, OP_REMU:              fix_val = rem_fix;
      default:                      fix_val = acc_q[W-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d  = op_in;
          cnt_d = '0;
          if (div0) begin
            // Preload {rem, quo} so FIX passes them through unchanged.
            state_d = FIX;
            acc_d   = {bus.src_a_i, DIV0_QUO};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
          end else if (ovf) begin
            state_d = FIX;
            acc_d   = {OVF_REM, MIN_NEG};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
          end else begin
            state_d = CALC;
            acc_d   = '0;
            a_d     = mag_a;
            b_d     = mag_b;
            neg_q_d = neg_a ^ neg_b;
            neg_r_d = neg_a;
          end
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            // Dividend bits stream in from a_q's MSB into the remainder half.
            a_d = a_q << 1;
            if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
            else           acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
          end else begin
            b_d   = b_q >> 1;
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          result_d = fix_val;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_q_d;
      neg_r    <= neg_r_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit for the execute stage. It sits beside the single-cycle ALU, takes one M-extension operation per start pulse, and runs a shift-add or restoring-divide loop for WIDTH cycles. It holds `busy_o` high so the hazard logic stalls the pipeline, then presents the result with a one-cycle `done_o`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `OPCODE_LENGTH`, default 3: width of `op_i`, which carries funct3 of the M instruction.
- `clk` in, 1 bit: single clock, all state on its rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `start_i` in, 1 bit: request. Sampled only in IDLE.
- `op_i` in, OPCODE_LENGTH bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a_i` in, DATA_WIDTH bits: rs1 value. Latched at accept.
- `src_b_i` in, DATA_WIDTH bits: rs2 value. Latched at accept.
- `flush_i` in, 1 bit: abort the current operation (branch mispredict or trap).
- `busy_o` out, 1 bit: high whenever state ≠ IDLE.
- `done_o` out, 1 bit: high exactly in state DONE.
- `result_o` out, DATA_WIDTH bits: registered result. Valid while `done_o` is high and held until the next accept.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **IDLE → CALC:** on `start_i && !flush_i`.
  - Latch the op.
  - Latch the operand magnitudes. Take the absolute value for the signed operand(s) of each op: MULHSU treats rs1 signed and rs2 unsigned.
  - Record `neg_q` and `neg_r` sign flags.
  - Clear the iteration counter and the 2·DATA_WIDTH accumulator.
- **IDLE → FIX (fast path):** these cases skip CALC and preload the result:
  - Divide by zero: quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow (rs1 = 0x80000000, rs2 = −1, DIV/REM): quotient = 0x80000000; remainder = 0.
- **CALC:** one iteration per cycle, counter 0..DATA_WIDTH−1.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half. Then shift the 64-bit accumulator right by 1.
  - Divide (restoring): shift {rem, quo} left by 1. Trial-subtract the divisor from rem; if the result is non-negative, keep it and set the quo LSB.
  - Leave for FIX when counter = DATA_WIDTH−1.
- **FIX:** apply sign correction, then go to DONE.
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word of the product, after 64-bit negation if `neg_q`.
  - DIV/DIVU: quotient, negated if `neg_q`.
  - REM/REMU: remainder, negated if `neg_r`. `neg_r` = sign of rs1.
  - Write `result_o`.
- **DONE → IDLE:** unconditional. `start_i` is ignored during DONE; the next request is accepted in IDLE.
- **Flush:** `flush_i` in CALC, FIX or DONE forces IDLE at the next edge.
  - `result_o` is not updated.
  - A flush during DONE still shows `done_o` for that cycle.
  - In IDLE, `flush_i` with `start_i` in the same cycle means no accept; flush wins.
- **Start while busy:** ignored, with no queueing. Operands may change freely while busy.
- **Arithmetic:** all arithmetic is unsigned on magnitudes. The negation of 0x80000000 wraps to itself, which the FIX rules rely on.

## Timing
- **Reset:** state IDLE, `busy_o` = 0, `done_o` = 0, `result_o` = 0, counter = 0, accumulator = 0.
- **Reset mid-operation:** same values at the next edge. No `done_o` is produced.
- **Normal latency:** accept at edge k; CALC on edges k+1..k+DATA_WIDTH; FIX at edge k+DATA_WIDTH+1. `done_o` is high for the cycle after edge k+33 (DATA_WIDTH = 32). IDLE follows at edge k+34, and a back-to-back accept is possible at k+35.
- **Fast-path latency:** accept at edge k, FIX at edge k+1. `done_o` is high in the cycle after k+1.
- **`busy_o`:** rises the cycle after accept and falls the cycle after DONE. It is never combinationally dependent on `start_i`; the stall logic ORs `start_i` itself.
- **Single-cycle outputs:** `done_o` is never high for two consecutive cycles.

## Structure
- **Package `muldiv_pkg`:**
  - `muldiv_op_e` enum of the eight funct3 codes.
  - `muldiv_state_e`: IDLE, CALC, FIX, DONE.
  - `MULDIV_CNT_W` = $clog2(DATA_WIDTH).
  - Localparams for the divide-by-zero and overflow constants.
- **Sub-modules:** none. The datapath and FSM sit in one module; the iteration adder/subtractor is inline, not the shared ALU.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result_o` = 0xFFFFFFEB. `done_o` asserts exactly 33 cycles after the accept edge; `busy_o` is high throughout.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, both with 2-cycle latency. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- `flush_i` on the 10th CALC cycle → IDLE next edge, no `done_o`, `result_o` keeps its prior value. `start_i` held high during CALC is ignored; the next accept occurs only after DONE.
- `reset` asserted mid-CALC → all outputs 0 at the next edge. A fresh MUL 3 × 4 afterwards → 12 with normal latency.
